gun_hit_detector: RTL and testbench

//  Light-gun reader: the read-back end of the VGA pixel path. On a debounced trigger pull it

---
 rtl/dh_pkg.sv | 19 +
 rtl/gun_debounce.sv | 49 ++++
 rtl/gun_hit_detector.sv | 161 ++++++++++++++++
 tb/tb_gun_hit_detector.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dh_pkg.sv
// Shared types and default tuning constants for the light-gun reader and ctl_duck.
package dh_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        DARK,
        TARGET,
        VERDICT,
        COOLDOWN
    } gun_state_t;

    localparam int GUN_DEBOUNCE_CYCLES = 65_000;
    localparam int GUN_LIGHT_MIN       = 2048;
    localparam int GUN_DARK_MAX        = 256;
    localparam int GUN_COOLDOWN_FRAMES = 15;
    localparam int GUN_CNT_W           = 20;

endpackage

// File: rtl/gun_debounce.sv
// Trigger conditioning: 2-FF synchronizer, stability counter, one-cycle pulse per accepted
// low->high change of the stable level.
module gun_debounce
    import dh_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = GUN_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    output logic rise_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            rise_q;
    logic [DB_W-1:0] cnt_q;

    // The counter only runs while the synced level disagrees with the stable level,
    // so any glitch back to the stable level restarts the qualification window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= trig_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_q <= sync2_q;
                rise_q   <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/gun_hit_detector.sv
// Light-gun reader: black frame, then target frame, photodetector counts decide hit/miss.
// Define GUN_DEBUG_CNT_EN to expose the last target-frame light count on dbg_light_cnt.
module gun_hit_detector
    import dh_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = GUN_DEBOUNCE_CYCLES,
    parameter int LIGHT_MIN       = GUN_LIGHT_MIN,
    parameter int DARK_MAX        = GUN_DARK_MAX,
    parameter int COOLDOWN_FRAMES = GUN_COOLDOWN_FRAMES,
    parameter int CNT_W           = GUN_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_frame,
    input  logic             gun_trigger,
    input  logic             gun_photodetector,
    input  logic             duck_show,
    output logic             flash_black,
    output logic             flash_target,
    output logic             shot_fired,
    output logic             duck_hit,
    output logic             duck_miss,
    output logic             busy,
    output logic [CNT_W-1:0] dbg_light_cnt
);

    localparam int COOL_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  LIGHT_MIN_C = CNT_W'(LIGHT_MIN);
    localparam logic [CNT_W-1:0]  DARK_MAX_C  = CNT_W'(DARK_MAX);
    localparam logic [COOL_W-1:0] COOL_LAST_C = COOL_W'(COOLDOWN_FRAMES - 1);

    gun_state_t        state_q, state_d;
    logic [CNT_W-1:0]  dark_cnt_q, dark_cnt_d;
    logic [CNT_W-1:0]  light_cnt_q, light_cnt_d;
    logic [COOL_W-1:0] cool_q, cool_d;
    logic              shot_q, shot_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;
    logic              flash_black_q, flash_target_q;
    logic              pd_s1_q, pd_s2_q;
    logic              trig_rise;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    gun_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .trig_i(gun_trigger),
        .rise_o(trig_rise)
    );

    always_comb begin
        state_d     = state_q;
        dark_cnt_d  = dark_cnt_q;
        light_cnt_d = light_cnt_q;
        cool_d      = cool_q;
        shot_d      = 1'b0;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    shot_d = 1'b1;
                    if (duck_show) begin
                        state_d = ARM;
                    end else begin
                        miss_d  = 1'b1;
                        cool_d  = '0;
                        state_d = COOLDOWN;
                    end
                end
            end
            ARM, DARK, TARGET: begin
                if (!duck_show) begin
                    // Duck left the screen mid-measurement: the shot cannot hit.
                    miss_d  = 1'b1;
                    cool_d  = '0;
                    state_d = COOLDOWN;
                end else if (state_q == ARM) begin
                    if (new_frame) begin
                        dark_cnt_d  = '0;
                        light_cnt_d = '0;
                        state_d     = DARK;
                    end
                end else if (state_q == DARK) begin
                    dark_cnt_d = sat_inc(dark_cnt_q, pd_s2_q);
                    if (new_frame) state_d = TARGET;
                end else begin
                    light_cnt_d = sat_inc(light_cnt_q, pd_s2_q);
                    if (new_frame) state_d = VERDICT;
                end
            end
            VERDICT: begin
                if ((dark_cnt_q <= DARK_MAX_C) && (light_cnt_q >= LIGHT_MIN_C)) hit_d = 1'b1;
                else miss_d = 1'b1;
                cool_d  = '0;
                state_d = COOLDOWN;
            end
            COOLDOWN: begin
                if (new_frame) begin
                    if (cool_q == COOL_LAST_C) state_d = IDLE;
                    else cool_d = cool_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            dark_cnt_q     <= '0;
            light_cnt_q    <= '0;
            cool_q         <= '0;
            shot_q         <= 1'b0;
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
            flash_black_q  <= 1'b0;
            flash_target_q <= 1'b0;
            pd_s1_q        <= 1'b0;
            pd_s2_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            dark_cnt_q     <= dark_cnt_d;
            light_cnt_q    <= light_cnt_d;
            cool_q         <= cool_d;
            shot_q         <= shot_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
            flash_black_q  <= (state_d == DARK);
            flash_target_q <= (state_d == TARGET);
            pd_s1_q        <= gun_photodetector;
            pd_s2_q        <= pd_s1_q;
        end
    end

`ifdef GUN_DEBUG_CNT_EN
    logic [CNT_W-1:0] dbg_light_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dbg_light_q <= '0;
        else if (state_q == VERDICT) dbg_light_q <= light_cnt_q;
    end

    assign dbg_light_cnt = dbg_light_q;
`else
    assign dbg_light_cnt = '0;
`endif

    assign flash_black  = flash_black_q;
    assign flash_target = flash_target_q;
    assign shot_fired   = shot_q;
    assign duck_hit     = hit_q;
    assign duck_miss    = miss_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_gun_hit_detector.sv
// Directed bench for gun_hit_detector with shortened debounce, frame and cooldown timing.
module tb_gun_hit_detector;

    localparam int DEB   = 32;
    localparam int FRAME = 270;
    localparam int LMIN  = 100;
    localparam int DMAX  = 20;
    localparam int CFR   = 3;
    localparam int CW    = 8;
    localparam logic [1:0] V_HIT  = 2'b10;
    localparam logic [1:0] V_MISS = 2'b01;

    logic          clk, rst, new_frame, gun_trigger, gun_photodetector, duck_show;
    logic          flash_black, flash_target, shot_fired, duck_hit, duck_miss, busy;
    logic [CW-1:0] dbg_light_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q[$];

    int shot_cnt, coincide_cnt, both_cnt, overlap_cnt;
    int black_rise, target_rise, black_len, target_len;
    logic prev_black, prev_target;

    // sensor model knobs
    bit lamp_mode;
    int lit_n;
    int tgt_age;

    gun_hit_detector #(
        .DEBOUNCE_CYCLES(DEB),
        .LIGHT_MIN      (LMIN),
        .DARK_MAX       (DMAX),
        .COOLDOWN_FRAMES(CFR),
        .CNT_W          (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .new_frame        (new_frame),
        .gun_trigger      (gun_trigger),
        .gun_photodetector(gun_photodetector),
        .duck_show        (duck_show),
        .flash_black      (flash_black),
        .flash_target     (flash_target),
        .shot_fired       (shot_fired),
        .duck_hit         (duck_hit),
        .duck_miss        (duck_miss),
        .busy             (busy),
        .dbg_light_cnt    (dbg_light_cnt)
    );

    // clock / frame / sensor
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        new_frame = 1'b0;
        forever begin
            repeat (FRAME - 1) @(negedge clk);
            new_frame = 1'b1;
            @(negedge clk);
            new_frame = 1'b0;
        end
    end

    initial begin
        gun_photodetector = 1'b0;
        tgt_age = 0;
        forever begin
            @(negedge clk);
            tgt_age = flash_target ? tgt_age + 1 : 0;
            if (lamp_mode) gun_photodetector = flash_black | flash_target;
            else gun_photodetector = flash_target && (tgt_age >= 1) && (tgt_age <= lit_n);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // monitor + scoreboard
    initial begin
        prev_black  = 1'b0;
        prev_target = 1'b0;
        forever begin
            @(negedge clk);
            shot_cnt     += int'(shot_fired);
            coincide_cnt += int'(shot_fired & duck_miss);
            both_cnt     += int'(duck_hit & duck_miss);
            overlap_cnt  += int'(flash_black & flash_target);
            black_len    += int'(flash_black);
            target_len   += int'(flash_target);
            if (flash_black && !prev_black) black_rise++;
            if (flash_target && !prev_target) target_rise++;
            prev_black  = flash_black;
            prev_target = flash_target;
            if (duck_hit || duck_miss) begin
                if (exp_q.size() == 0) check("unexpected_verdict", {duck_hit, duck_miss}, 2'b00);
                else check("verdict", {duck_hit, duck_miss}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic clear_stats();
        shot_cnt = 0; coincide_cnt = 0; black_rise = 0; target_rise = 0;
        black_len = 0; target_len = 0;
    endtask

    task automatic wait_sig(input int which, input logic level, input int budget, input string tag);
        logic v;
        v = ~level;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (which)
                0: v = busy;
                1: v = flash_black;
                default: v = flash_target;
            endcase
            if (v == level) break;
        end
        check(tag, v, level);
    endtask

    task automatic settle_trigger(input logic level);
        gun_trigger = level;
        repeat (DEB + 10) @(negedge clk);
    endtask

    task automatic run_shot(input string tag, input logic [1:0] verdict, input int n_lit, input bit lamp);
        lamp_mode = lamp;
        lit_n = n_lit;
        clear_stats();
        exp_q.push_back(verdict);
        gun_trigger = 1'b1;
        wait_sig(0, 1'b1, DEB + 20, {tag, "_busy_rise"});
        wait_sig(0, 1'b0, 8 * FRAME, {tag, "_busy_fall"});
        settle_trigger(1'b0);
        check({tag, "_shots"}, shot_cnt, 1);
        check({tag, "_black_frames"}, black_rise, 1);
        check({tag, "_target_frames"}, target_rise, 1);
        check({tag, "_black_len"}, black_len, FRAME);
        check({tag, "_target_len"}, target_len, FRAME);
    endtask

    initial begin
        rst = 1'b1;
        gun_trigger = 1'b0;
        duck_show = 1'b1;
        lamp_mode = 1'b0;
        lit_n = 0;
        clear_stats();
        both_cnt = 0;
        overlap_cnt = 0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_flash_black", flash_black, 0);
        check("rst_flash_target", flash_target, 0);
        check("rst_shot", shot_fired, 0);
        check("rst_hit", duck_hit, 0);
        check("rst_miss", duck_miss, 0);
        check("rst_busy", busy, 0);
        check("rst_dbg", dbg_light_cnt, 0);

        // 150 lit target cycles, dark clean: hit
        run_shot("hit", V_HIT, 150, 1'b0);
`ifdef GUN_DEBUG_CNT_EN
        check("hit_dbg", dbg_light_cnt, 150);
`else
        check("hit_dbg", dbg_light_cnt, 0);
`endif

        // 60 lit target cycles: below LMIN
        run_shot("dim", V_MISS, 60, 1'b0);

        // lamp: dark count saturates at 255 > DMAX
        run_shot("lamp", V_MISS, 0, 1'b1);
`ifdef GUN_DEBUG_CNT_EN
        check("lamp_dbg", dbg_light_cnt, 255);
`else
        check("lamp_dbg", dbg_light_cnt, 0);
`endif
        lamp_mode = 1'b0;

        // bounce then stable pull, second pull during cooldown ignored
        clear_stats();
        lit_n = 150;
        exp_q.push_back(V_HIT);
        for (int i = 0; i < 10; i++) begin
            gun_trigger = ~gun_trigger;
            repeat (DEB / 3) @(negedge clk);
        end
        gun_trigger = 1'b1;
        wait_sig(2, 1'b1, 4 * FRAME, "bounce_target_on");
        wait_sig(2, 1'b0, 2 * FRAME, "bounce_target_off");
        settle_trigger(1'b0);
        settle_trigger(1'b1);
        check("cooldown_busy", busy, 1);
        settle_trigger(1'b0);
        wait_sig(0, 1'b0, 6 * FRAME, "bounce_idle");
        check("bounce_shots", shot_cnt, 1);

        // no duck on screen: immediate miss, no flash
        clear_stats();
        duck_show = 1'b0;
        exp_q.push_back(V_MISS);
        gun_trigger = 1'b1;
        wait_sig(0, 1'b1, DEB + 20, "noduck_busy_rise");
        wait_sig(0, 1'b0, 6 * FRAME, "noduck_busy_fall");
        settle_trigger(1'b0);
        check("noduck_shots", shot_cnt, 1);
        check("noduck_shot_with_miss", coincide_cnt, 1);
        check("noduck_black", black_rise, 0);
        check("noduck_target", target_rise, 0);
        duck_show = 1'b1;

        // duck leaves during target frame: abort
        clear_stats();
        exp_q.push_back(V_MISS);
        gun_trigger = 1'b1;
        wait_sig(2, 1'b1, DEB + 3 * FRAME, "abort_target_on");
        duck_show = 1'b0;
        @(negedge clk);
        check("abort_target_drop", flash_target, 0);
        check("abort_miss", duck_miss, 1);
        wait_sig(0, 1'b0, 6 * FRAME, "abort_idle");
        settle_trigger(1'b0);
        duck_show = 1'b1;
        check("abort_shots", shot_cnt, 1);

        // reset mid-dark: outputs clear at once, no verdict
        gun_trigger = 1'b1;
        wait_sig(1, 1'b1, DEB + 3 * FRAME, "rstmid_black_on");
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_flash_black", flash_black, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_miss", duck_miss, 0);
        gun_trigger = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        check("rstmid_no_verdict", exp_q.size(), 0);
        run_shot("after_rst", V_HIT, 150, 1'b0);

        check("hit_miss_exclusive", both_cnt, 0);
        check("flash_exclusive", overlap_cnt, 0);
        check("verdicts_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
